// File: rtl/serial_com_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_com_rx
// Purpose  : Bit-serial frame receiver: hunts a 16-bit header, collects a
//            3-byte payload and checks a 16-bit delimiter, with idle timeout.
// Revision : 1.0
// ============================================================================
module serial_com_rx #(
    parameter logic [15:0] HEADER         = 16'hA5A5,
    parameter logic [15:0] DELIMITER      = 16'h5A5A,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bit_valid,
    input  logic       serial_in,
    output logic [7:0] payload0,
    output logic [7:0] payload1,
    output logic [7:0] payload2,
    output logic       frame_valid,
    output logic       frame_error,
    output logic       rx_busy,
    output logic [7:0] frame_count,
    output logic [7:0] error_count
);

    localparam int c_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        DELIM   = 2'd2
    } state_t;

    state_t              r_state;
    logic [15:0]         r_shift;
    logic [23:0]         r_stage;
    logic [4:0]          r_bit_cnt;
    logic [c_IDLE_W-1:0] r_idle;

    logic [15:0]         w_shift_next;
    logic [23:0]         w_stage_next;
    logic                w_idle_last;
    logic [7:0]          w_error_inc;

    assign w_shift_next = {r_shift[14:0], serial_in};
    assign w_stage_next = {r_stage[22:0], serial_in};
    assign w_idle_last  = (r_idle == c_IDLE_W'(TIMEOUT_CYCLES - 1));
    assign w_error_inc  = (error_count == 8'hFF) ? error_count : error_count + 8'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= HUNT;
            r_shift     <= '0;
            r_stage     <= '0;
            r_bit_cnt   <= '0;
            r_idle      <= '0;
            payload0    <= '0;
            payload1    <= '0;
            payload2    <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            rx_busy     <= 1'b0;
            frame_count <= '0;
            error_count <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (r_state)
                HUNT: begin
                    r_idle <= '0;
                    if (bit_valid) begin
                        r_shift <= w_shift_next;
                        if (w_shift_next == HEADER) begin
                            r_state   <= PAYLOAD;
                            r_bit_cnt <= '0;
                            rx_busy   <= 1'b1;
                        end
                    end
                end
                PAYLOAD, DELIM: begin
                    if (bit_valid) begin
                        r_idle <= '0;
                        if (r_state == PAYLOAD) begin
                            r_stage <= w_stage_next;
                            if (r_bit_cnt == 5'd23) begin
                                r_state   <= DELIM;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end else begin
                            r_shift <= w_shift_next;
                            if (r_bit_cnt == 5'd15) begin
                                // Clearing the shift register keeps delimiter bits out of the next header hunt.
                                r_state   <= HUNT;
                                r_shift   <= '0;
                                r_bit_cnt <= '0;
                                rx_busy   <= 1'b0;
                                if (w_shift_next == DELIMITER) begin
                                    frame_valid <= 1'b1;
                                    payload0    <= r_stage[23:16];
                                    payload1    <= r_stage[15:8];
                                    payload2    <= r_stage[7:0];
                                    frame_count <= frame_count + 8'd1;
                                end else begin
                                    frame_error <= 1'b1;
                                    error_count <= w_error_inc;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end else if (w_idle_last) begin
                        r_state     <= HUNT;
                        r_shift     <= '0;
                        r_bit_cnt   <= '0;
                        r_idle      <= '0;
                        rx_busy     <= 1'b0;
                        frame_error <= 1'b1;
                        error_count <= w_error_inc;
                    end else begin
                        r_idle <= r_idle + c_IDLE_W'(1);
                    end
                end
                default: begin
                    r_state <= HUNT;
                    r_shift <= '0;
                    r_idle  <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_com_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_com_rx
// Purpose  : Scoreboard bench for serial_com_rx with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_serial_com_rx;

    localparam logic [15:0] HDR = 16'hA5A5;
    localparam logic [15:0] DLM = 16'h5A5A;

    logic       clock = 1'b0;
    logic       reset;
    logic       bit_valid;
    logic       serial_in;
    logic [7:0] payload0, payload1, payload2;
    logic       frame_valid, frame_error, rx_busy;
    logic [7:0] frame_count, error_count;

    serial_com_rx #(.HEADER(HDR), .DELIMITER(DLM), .TIMEOUT_CYCLES(1024)) dut (
        .clock(clock), .reset(reset), .bit_valid(bit_valid), .serial_in(serial_in),
        .payload0(payload0), .payload1(payload1), .payload2(payload2),
        .frame_valid(frame_valid), .frame_error(frame_error), .rx_busy(rx_busy),
        .frame_count(frame_count), .error_count(error_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         ok;
        logic [7:0] p0, p1, p2, fc, ec;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         m_fc, m_ec;
    logic [7:0] m_p0, m_p1, m_p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fc = 0; m_ec = 0; m_p0 = 0; m_p1 = 0; m_p2 = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send_bit(input bit b, input int gap);
        repeat (gap) @(posedge clock);
        #1;
        bit_valid = 1'b1;
        serial_in = b;
        @(posedge clock);
        #1;
        bit_valid = 1'b0;
        serial_in = 1'($urandom);
    endtask

    task automatic send_word(input logic [31:0] v, input int n, input int glo, input int ghi);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], int'($urandom_range(ghi, glo)));
    endtask

    // Expected outcome is decided from the frame contents alone.
    task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                              input logic [15:0] dl, input int glo, input int ghi);
        exp_t e;
        if (dl == DLM) begin
            m_fc = (m_fc + 1) % 256;
            m_p0 = p0; m_p1 = p1; m_p2 = p2;
            e.ok = 1'b1;
        end else begin
            m_ec = (m_ec < 255) ? m_ec + 1 : 255;
            e.ok = 1'b0;
        end
        e.p0 = m_p0; e.p1 = m_p1; e.p2 = m_p2; e.fc = 8'(m_fc); e.ec = 8'(m_ec);
        sb.push_back(e);
        send_word({16'h0, HDR}, 16, glo, ghi);
        send_word({8'h0, p0, p1, p2}, 24, glo, ghi);
        send_word({16'h0, dl}, 16, glo, ghi);
        chk("pulse_latency", {31'b0, frame_valid | frame_error}, 1);
    endtask

    // Garbage is accepted only if no header can appear before the intended one.
    function automatic bit garbage_clean(input bit g[$]);
        bit s[$];
        logic [15:0] w;
        for (int i = 0; i < 16; i++) s.push_back(1'b0);
        foreach (g[i]) s.push_back(g[i]);
        for (int i = 15; i >= 0; i--) s.push_back(HDR[i]);
        for (int e = 15; e <= s.size() - 2; e++) begin
            for (int k = 0; k < 16; k++) w[15 - k] = s[e - 15 + k];
            if (w == HDR) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic send_garbage(input int n, input int ghi);
        bit g[$];
        do begin
            g.delete();
            for (int i = 0; i < n; i++) g.push_back(1'($urandom));
        end while (!garbage_clean(g));
        foreach (g[i]) send_bit(g[i], int'($urandom_range(ghi, 0)));
    endtask

    initial begin
        exp_t e;
        int   k;
        reset = 1'b1; bit_valid = 1'b0; serial_in = 1'b0;
        model_reset();

        fork
            forever begin
                @(negedge clock);
                if (!reset && frame_valid && frame_error)
                    chk("both_pulses", 1, 0);
                if (!reset && (frame_valid || frame_error)) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", {30'b0, frame_valid, frame_error}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("pulse_kind", {31'b0, frame_valid}, {31'b0, e.ok});
                        chk("payload", {8'h0, payload0, payload1, payload2}, {8'h0, e.p0, e.p1, e.p2});
                        chk("counts", {16'h0, frame_count, error_count}, {16'h0, e.fc, e.ec});
                    end
                end
            end
        join_none

        repeat (3) @(posedge clock);
        #1;
        chk("rst_payload", {8'h0, payload0, payload1, payload2}, 0);
        chk("rst_flags", {29'b0, frame_valid, frame_error, rx_busy}, 0);
        chk("rst_counts", {16'h0, frame_count, error_count}, 0);
        do_reset();

        send_frame(8'h0A, 8'h14, 8'h1E, DLM, 15, 15);
        chk("first_fc", {24'h0, frame_count}, 1);

        send_word(0, 20, 0, 0);
        send_frame(8'h0A, 8'h14, 8'h1E, DLM, 0, 2);
        send_word(0, 9, 0, 0);
        send_frame(8'h0A, 8'h14, 8'h1E, DLM, 0, 2);
        chk("two_frames", {16'h0, frame_count, error_count}, {16'h0, 8'd3, 8'd0});

        send_frame(8'h11, 8'h22, 8'h33, 16'h5A5B, 0, 1);
        chk("bad_keeps_payload", {8'h0, payload0, payload1, payload2}, 32'h000A141E);

        m_ec = (m_ec < 255) ? m_ec + 1 : 255;
        e.ok = 1'b0; e.p0 = m_p0; e.p1 = m_p1; e.p2 = m_p2; e.fc = 8'(m_fc); e.ec = 8'(m_ec);
        sb.push_back(e);
        send_word({16'h0, HDR}, 16, 0, 1);
        send_word(32'h2A5, 10, 0, 1);
        chk("busy_in_frame", {31'b0, rx_busy}, 1);
        k = 1;
        while (k <= 1100) begin
            @(posedge clock);
            #1;
            if (frame_error) break;
            k++;
        end
        chk("timeout_cycle", k, 1024);
        chk("busy_after_timeout", {31'b0, rx_busy}, 0);
        send_frame(8'hC3, 8'h5E, 8'h71, DLM, 0, 3);

        send_word({16'h0, HDR}, 16, 0, 1);
        send_word(32'h3FFF, 14, 0, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        chk("midrst_payload", {8'h0, payload0, payload1, payload2}, 0);
        chk("midrst_flags", {29'b0, frame_valid, frame_error, rx_busy}, 0);
        chk("midrst_counts", {16'h0, frame_count, error_count}, 0);
        send_frame(8'h01, 8'h02, 8'h03, DLM, 0, 1);
        chk("after_rst_fc", {24'h0, frame_count}, 1);

        for (int i = 0; i < 40; i++) begin
            send_garbage(int'($urandom_range(30, 0)), 3);
            send_frame(8'($urandom), 8'($urandom), 8'($urandom),
                       ($urandom_range(3, 0) == 0) ? (DLM ^ (16'h1 << $urandom_range(15, 0))) : DLM,
                       0, 3);
        end

        do_reset();
        for (int i = 0; i < 256; i++)
            send_frame(8'($urandom), 8'($urandom), 8'($urandom), DLM, 0, 0);
        chk("fc_wrap", {24'h0, frame_count}, 0);
        for (int i = 0; i < 300; i++)
            send_frame(8'($urandom), 8'($urandom), 8'($urandom), ~DLM, 0, 0);
        chk("ec_saturate", {24'h0, error_count}, 255);

        repeat (4) @(posedge clock);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_com_rx.md
SERIAL_COM_RX -- requirements
Module: serial_com_rx

Interface
REQ-001 SHALL provide parameter HEADER, 16'hA5A5, start-header pattern hunted for (MSB first).
REQ-002 SHALL provide parameter DELIMITER, 16'h5A5A, end-of-frame pattern checked after the payload.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, 1024, clock cycles without bit_valid before an in-frame abort.
REQ-004 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port bit_valid  input  1  one-clock strobe marking that serial_in holds a new bit.
REQ-007 SHALL have port serial_in  input  1  serial data bit; sampled only when bit_valid=1.
REQ-008 SHALL have port payload0  output  8  first payload byte of the last good frame.
REQ-009 SHALL have port payload1  output  8  second payload byte of the last good frame.
REQ-010 SHALL have port payload2  output  8  third payload byte of the last good frame.
REQ-011 SHALL have port frame_valid  output  1  one-clock pulse when a frame with a correct delimiter completes.
REQ-012 SHALL have port frame_error  output  1  one-clock pulse on a delimiter mismatch or a timeout abort.
REQ-013 SHALL have port rx_busy  output  1  high while in PAYLOAD or DELIM state.
REQ-014 SHALL have port frame_count  output  8  count of good frames, wrapping 255->0.
REQ-015 SHALL have port error_count  output  8  count of frame errors, saturating at 255.

Function
REQ-016 SHALL implement FSM states HUNT, PAYLOAD, DELIM; all bit sampling is qualified by bit_valid; cycles with bit_valid=0 do not shift or count.
REQ-017 HUNT SHALL shift serial_in into a 16-bit shift register (MSB first, new bit at LSB) on each bit_valid, and SHALL move to PAYLOAD in the same clock when the post-shift value equals HEADER; bit counter cleared.
REQ-018 HUNT SHALL detect a header at any bit alignment, including overlap with preceding idle or garbage bits.
REQ-019 PAYLOAD SHALL collect 24 bits MSB first into a staging register: bits 0-7 to byte0, bits 8-15 to byte1, bits 16-23 to byte2; on the 24th bit it SHALL go to DELIM with the counter cleared.
REQ-020 DELIM SHALL collect 16 bits; on the 16th bit it SHALL compare them against DELIMITER.
REQ-021 On a match, the next clock SHALL pulse frame_valid for 1 cycle, load payload0-2 from staging in that same cycle, and increment frame_count (modulo 256).
REQ-022 On a mismatch, the next clock SHALL pulse frame_error for 1 cycle and increment error_count (saturating); payload0-2 SHALL be unchanged.
REQ-023 After either outcome, the FSM SHALL return to HUNT with the shift register cleared to 0, so delimiter bits can never form part of the next header.
REQ-024 In PAYLOAD/DELIM, an idle counter SHALL count consecutive clocks with bit_valid=0 and clear on each bit_valid; when it reaches TIMEOUT_CYCLES, the FSM SHALL abort to HUNT, pulse frame_error, and increment error_count; payload0-2 SHALL be unchanged.
REQ-025 The idle counter SHALL be inactive and held at 0 in HUNT.
REQ-026 frame_valid and frame_error SHALL never be high in the same cycle.
REQ-027 rx_busy SHALL be registered and SHALL equal (state != HUNT).
REQ-028 Latency SHALL be exactly one clock from the bit_valid that carries the last delimiter bit to the frame_valid/frame_error pulse.

Reset
REQ-029 While reset=1, the block SHALL ignore bit_valid and drive state=HUNT, shift register=0, staging=0, idle counter=0, payload0-2=0, frame_valid=0, frame_error=0, rx_busy=0, frame_count=0, error_count=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no frame_error pulse; the first clock after release SHALL be in HUNT.

Verification
REQ-031 Stream A5A5 0A 14 1E 5A5A with bit_valid every 16 clocks -> one frame_valid pulse; payload0=0x0A, payload1=0x14, payload2=0x1E; frame_count=1.
REQ-032 Stream 20 zero bits, then the same frame, then 9 zero bits, then the frame again -> two frame_valid pulses; frame_count=2; error_count=0.
REQ-033 Stream A5A5 11 22 33 5A5B after a good frame -> frame_error pulse; error_count=1; payload0-2 still 0x0A/0x14/0x1E.
REQ-034 Stream the header plus 10 payload bits, then hold bit_valid=0 for 1024 clocks -> frame_error on the 1024th idle clock; rx_busy falls; a full frame sent next is received correctly.
REQ-035 Assert reset for 1 clock after 30 frame bits -> no pulses; all outputs 0; a following full frame gives frame_valid with frame_count=1.
REQ-036 Force 256 good frames -> frame_count wraps to 0; force 300 bad frames -> error_count holds at 255.
